// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle mult/div unit owning the HI/LO registers
// A captured operation completes after a fixed latency; new starts are ignored while busy.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StartE,
    input  logic [2:0]  MDOpE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [CW-1:0]  r_count;
    logic [31:0]    r_a;
    logic [31:0]    r_b;
    logic [2:0]     r_op;
    logic [31:0]    r_hi;
    logic [31:0]    r_lo;

    logic           w_accept;
    logic           w_done;
    logic           w_mthi;
    logic           w_mtlo;
    logic [31:0]    w_res_hi;
    logic [31:0]    w_res_lo;
    logic [63:0]    w_prod_s;
    logic [63:0]    w_prod_u;
    logic           w_bzero;
    logic           w_ovf;
    logic [31:0]    w_div_b;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;
    logic [31:0]    w_uq;
    logic [31:0]    w_ur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_mthi       = 1'b0;
        w_mtlo       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (StartE) begin
                    case (MDOpE)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            w_accept     = 1'b1;
                            w_next_state = S_RUN;
                        end
                        OP_MTHI: w_mthi = 1'b1;
                        OP_MTLO: w_mtlo = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (r_count == CW'(1)) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Special divides substitute a divisor of 1 so the dividers never see /0 or overflow.
    assign w_bzero  = (r_b == 32'd0);
    assign w_ovf    = (r_op == OP_DIV) && (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
    assign w_div_b  = (w_bzero || w_ovf) ? 32'd1 : r_b;
    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
    assign w_sq     = $signed(r_a) / $signed(w_div_b);
    assign w_sr     = $signed(r_a) % $signed(w_div_b);
    assign w_uq     = r_a / w_div_b;
    assign w_ur     = r_a % w_div_b;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (r_op)
            OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
            OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
            OP_DIV: begin
                if (w_bzero) begin
                    w_res_hi = r_a;
                    w_res_lo = 32'hFFFF_FFFF;
                end else if (w_ovf) begin
                    w_res_hi = 32'd0;
                    w_res_lo = 32'h8000_0000;
                end else begin
                    w_res_hi = w_sr;
                    w_res_lo = w_sq;
                end
            end
            OP_DIVU: begin
                if (w_bzero) begin
                    w_res_hi = r_a;
                    w_res_lo = 32'hFFFF_FFFF;
                end else begin
                    w_res_hi = w_ur;
                    w_res_lo = w_uq;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 3'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            if (w_accept) begin
                r_a     <= SrcAE;
                r_b     <= SrcBE;
                r_op    <= MDOpE;
                r_count <= (MDOpE == OP_MULT || MDOpE == OP_MULTU) ? CW'(MULT_CYCLES)
                                                                    : CW'(DIV_CYCLES);
            end else if (r_state == S_RUN) begin
                r_count <= r_count - CW'(1);
            end
            if (w_done) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else begin
                if (w_mthi) r_hi <= SrcAE;
                if (w_mtlo) r_lo <= SrcAE;
            end
        end
    end

    assign Busy = (r_state == S_RUN);
    assign HI   = r_hi;
    assign LO   = r_lo;
endmodule
